wb_xfer_buffer: RTL and testbench
=================================

WB_XFER_BUFFER -- requirements
Module: wb_xfer_buffer

Interface
REQ-001 SHALL have parameters: WIDTH=32, data width; SBITS=10, buffer address bits; COUNT=575, words per fetch minus one; DELAY=3, simulation register delay.
REQ-002 SHALL have clk_i, input, 1: sole clock, all state on rising edge.
REQ-003 SHALL have rst_i, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have enable_i, input, 1: level; permits automatic refetch.
REQ-005 SHALL have fetch_o, output, 1: one-cycle pulse requesting an upstream prefetch.
REQ-006 SHALL have valid_o, output, 1: buffer holds a complete block.
REQ-007 SHALL have error_o, output, 1: sticky, a write was discarded.
REQ-008 SHALL have write-slave inputs w_cyc_i, w_stb_i, w_we_i and w_bst_i (1 each), w_adr_i (SBITS) and w_dat_i (WIDTH).
REQ-009 SHALL have write-slave outputs w_ack_o and w_wat_o (1 each).
REQ-010 SHALL have read-slave inputs r_cyc_i, r_stb_i and r_we_i (1 each) and r_adr_i (SBITS).
REQ-011 SHALL have read-slave outputs r_ack_o and r_wat_o (1 each) and r_dat_o (WIDTH).

Function
REQ-012 SHALL implement states EMPTY, FILL and READY.
REQ-013 EMPTY -> FILL SHALL occur when enable_i=1; fetch_o SHALL pulse high for exactly that transition cycle.
REQ-014 FILL SHALL accept a write when w_cyc_i&w_stb_i&w_we_i, store w_dat_i at w_adr_i, and assert w_ack_o on the next cycle.
REQ-015 Writes with w_adr_i>COUNT SHALL be acked but not stored, and SHALL set error_o.
REQ-016 A fill counter (SBITS+1 bits) SHALL increment once per accepted in-range write; FILL -> READY SHALL occur when it reaches COUNT+1, and valid_o SHALL be registered high on that same edge.
REQ-017 Writes in EMPTY or READY SHALL be acked and discarded, and SHALL set error_o; w_wat_o SHALL be high in READY only.
REQ-018 Reads (r_cyc_i&r_stb_i&!r_we_i) in READY SHALL return the word at r_adr_i on r_dat_o with r_ack_o high exactly one cycle after the strobe; back-to-back strobes SHALL yield back-to-back acks.
REQ-019 Reads outside READY SHALL hold r_wat_o high and SHALL NOT ack until READY; the stalled request SHALL then complete with 1-cycle latency.
REQ-020 r_we_i=1 strobes SHALL be acked one cycle later with no effect.
REQ-021 An acked read of address COUNT SHALL move READY -> EMPTY, clear valid_o and zero the fill counter; if enable_i=1 the EMPTY -> FILL step SHALL follow on the next cycle.
REQ-022 A read and a write in the same cycle SHALL both proceed; there is no port conflict.
REQ-023 The fill counter SHALL NOT wrap; excess writes SHALL follow REQ-017.
REQ-024 Deasserting enable_i SHALL NOT abort FILL or READY; it only blocks leaving EMPTY.

Reset
REQ-025 Asserting rst_i SHALL immediately force state EMPTY, the fill counter to 0, and fetch_o, valid_o, error_o, w_ack_o, w_wat_o, r_ack_o and r_wat_o to 0.
REQ-026 Reset SHALL NOT clear RAM contents.
REQ-027 r_dat_o SHALL be 0 after reset until the first read.
REQ-028 Reset mid-FILL or mid-READY SHALL discard the block; a new fetch_o SHALL occur only after reset release with enable_i=1.

Structure
REQ-029 State encodings and default parameter values SHALL live in a shared include file used by the bus blocks.
REQ-030 Storage SHALL be one sub-module xfer_dpram: simple dual-port, 2^SBITS x WIDTH, one synchronous write port and one registered read port.
REQ-031 The control FSM, counter and ack logic SHALL be in wb_xfer_buffer.

Verification
REQ-032 Reset release, enable_i=1 -> fetch_o single pulse 1 cycle later; state FILL.
REQ-033 576 sequential writes, addr 0..575, data=addr^0xA5A5A5A5 -> valid_o high on the edge after the 576th accepted write; each w_ack_o 1 cycle after its strobe.
REQ-034 Stream reads addr 0..575 -> each returns addr^0xA5A5A5A5 with 1-cycle ack latency; after the ack for 575, valid_o=0 and fetch_o pulses (enable_i=1).
REQ-035 Read strobe at addr 3 during FILL -> r_wat_o held high, no ack until READY, then data for addr 3.
REQ-036 Write to addr 600 in FILL, then a write in READY -> both acked, neither stored, error_o=1 and sticky, fill counter unchanged.
REQ-037 rst_i asserted after 100 writes -> all outputs 0 asynchronously; a refill then needs the full 576 writes.

Source files
------------

// File: rtl/wb_xfer_buffer_pkg.sv
// Shared definitions for the transfer buffer: default parameter values and the
// control state encoding. Imported by the interface, the storage block and the
// control block so that all of them agree on sizes and state names.
package wb_xfer_buffer_pkg;

    localparam int unsigned DEF_WIDTH = 32;   // data width
    localparam int unsigned DEF_SBITS = 10;   // buffer address bits
    localparam int unsigned DEF_COUNT = 575;  // words per fetch minus one
    localparam int unsigned DEF_DELAY = 3;    // register delay of timed models

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,  // no block held, waiting for permission to fetch
        ST_FILL  = 2'd1,  // upstream is writing the block
        ST_READY = 2'd2   // complete block held, downstream may read it
    } state_e;

endpackage

// File: rtl/wb_xfer_buffer_if.sv
// Bus bundle for the transfer buffer: a write slave channel (filled by the
// upstream prefetcher) and a read slave channel (drained by the consumer).
//   write: w_cyc_i, w_stb_i, w_we_i, w_bst_i, w_adr_i, w_dat_i -> w_ack_o, w_wat_o
//   read : r_cyc_i, r_stb_i, r_we_i, r_adr_i -> r_ack_o, r_wat_o, r_dat_o
// The slave modport is the buffer's view; master is the bus driver's view.
interface wb_xfer_buffer_if
    import wb_xfer_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SBITS = DEF_SBITS
);
    logic             w_cyc_i;
    logic             w_stb_i;
    logic             w_we_i;
    logic             w_bst_i;
    logic [SBITS-1:0] w_adr_i;
    logic [WIDTH-1:0] w_dat_i;
    logic             w_ack_o;
    logic             w_wat_o;

    logic             r_cyc_i;
    logic             r_stb_i;
    logic             r_we_i;
    logic [SBITS-1:0] r_adr_i;
    logic             r_ack_o;
    logic             r_wat_o;
    logic [WIDTH-1:0] r_dat_o;

    modport slave (
        input  w_cyc_i, w_stb_i, w_we_i, w_bst_i, w_adr_i, w_dat_i,
        output w_ack_o, w_wat_o,
        input  r_cyc_i, r_stb_i, r_we_i, r_adr_i,
        output r_ack_o, r_wat_o, r_dat_o
    );

    modport master (
        output w_cyc_i, w_stb_i, w_we_i, w_bst_i, w_adr_i, w_dat_i,
        input  w_ack_o, w_wat_o,
        output r_cyc_i, r_stb_i, r_we_i, r_adr_i,
        input  r_ack_o, r_wat_o, r_dat_o
    );

endinterface

// File: rtl/wb_xfer_buffer_dpram.sv
// xfer_dpram: simple dual-port RAM, 2^SBITS words of WIDTH bits.
// Ports: clk_i/rst_i clock and async active-high reset (read register only);
//        we/waddr/wdata synchronous write port;
//        re/raddr/rdata registered read port, rdata updates only when re is high.
module xfer_dpram
    import wb_xfer_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SBITS = DEF_SBITS
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we,
    input  logic [SBITS-1:0] waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [SBITS-1:0] raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [2**SBITS];

    // NOTE: the array has no reset so it maps onto block RAM; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (we) mem[waddr] <= wdata;
    end

    // NOTE: non-blocking assignment in every clocked block keeps all flops
    // sampling pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/wb_xfer_buffer.sv
// wb_xfer_buffer: single-block transfer buffer between an upstream prefetcher
// (write channel) and a downstream consumer (read channel).
// Ports: clk_i, rst_i (async, active-high); enable_i permits automatic refetch;
//        fetch_o one-cycle prefetch request; valid_o complete block held;
//        error_o sticky discarded-write flag; bus = write and read slave channels.
// Flow: EMPTY -> FILL (fetch_o) -> READY after COUNT+1 in-range writes ->
//       EMPTY once the word at address COUNT has been read.
module wb_xfer_buffer
    import wb_xfer_buffer_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned SBITS = DEF_SBITS,
    parameter int unsigned COUNT = DEF_COUNT,
    parameter int unsigned DELAY = DEF_DELAY
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            enable_i,
    output logic            fetch_o,
    output logic            valid_o,
    output logic            error_o,
    wb_xfer_buffer_if.slave bus
);
    localparam logic [SBITS:0]   FILL_DONE = (SBITS+1)'(COUNT + 1);
    localparam logic [SBITS:0]   LAST_WIDE = (SBITS+1)'(COUNT);
    localparam logic [SBITS-1:0] LAST_ADDR = SBITS'(COUNT);

    state_e           state_q, state_d;
    logic [SBITS:0]   fill_cnt_q, fill_cnt_d;
    logic             fetch_d, valid_d, error_d;
    logic             mem_we, mem_re;
    logic             w_req, w_wr, w_in_range;
    logic             r_req, r_rd;
    logic [WIDTH-1:0] rd_data;

    // DELAY only shaped the timed behavioural model; single-beat writes give
    // w_bst_i no meaning here.
    logic [31:0] unused_delay;
    logic        unused_bst;
    assign unused_delay = 32'(DELAY);
    assign unused_bst   = bus.w_bst_i;

    assign w_req      = bus.w_cyc_i & bus.w_stb_i;
    assign w_wr       = w_req & bus.w_we_i;
    assign w_in_range = {1'b0, bus.w_adr_i} <= LAST_WIDE;
    assign r_req      = bus.r_cyc_i & bus.r_stb_i;
    assign r_rd       = r_req & ~bus.r_we_i;

    // Writes never stall (out-of-state writes are acked and dropped), so
    // w_wat_o is purely a "block is full" indication.
    assign bus.w_wat_o = (state_q == ST_READY);
    // Reads stall until a block is ready; gated by rst_i so it drops at once.
    assign bus.r_wat_o = r_rd & (state_q != ST_READY) & ~rst_i;
    assign bus.r_dat_o = rd_data;

    always_comb begin
        // NOTE: defaults first so no path leaves a variable unassigned, which
        // would otherwise infer a latch.
        state_d    = state_q;
        fill_cnt_d = fill_cnt_q;
        valid_d    = valid_o;
        error_d    = error_o;
        fetch_d    = 1'b0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        unique case (state_q)
            ST_EMPTY: begin
                if (enable_i) begin
                    state_d = ST_FILL;
                    fetch_d = 1'b1;
                end
                if (w_wr) error_d = 1'b1;
            end
            ST_FILL: begin
                if (w_wr && w_in_range) begin
                    mem_we     = 1'b1;
                    fill_cnt_d = fill_cnt_q + 1'b1;
                    if (fill_cnt_d == FILL_DONE) begin
                        state_d = ST_READY;
                        valid_d = 1'b1;
                    end
                end else if (w_wr) begin
                    error_d = 1'b1;
                end
            end
            ST_READY: begin
                if (w_wr) error_d = 1'b1;
                if (r_rd) begin
                    mem_re = 1'b1;
                    // The block is released on the same edge that acks its last word.
                    if (bus.r_adr_i == LAST_ADDR) begin
                        state_d    = ST_EMPTY;
                        valid_d    = 1'b0;
                        fill_cnt_d = '0;
                    end
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_EMPTY;
            fill_cnt_q  <= '0;
            fetch_o     <= 1'b0;
            valid_o     <= 1'b0;
            error_o     <= 1'b0;
            bus.w_ack_o <= 1'b0;
            bus.r_ack_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_cnt_q  <= fill_cnt_d;
            fetch_o     <= fetch_d;
            valid_o     <= valid_d;
            error_o     <= error_d;
            bus.w_ack_o <= w_req;
            // Control strobes (r_we_i) complete in any state; reads only when READY.
            bus.r_ack_o <= r_req & (bus.r_we_i | (state_q == ST_READY));
        end
    end

    xfer_dpram #(
        .WIDTH (WIDTH),
        .SBITS (SBITS)
    ) u_ram (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .we    (mem_we),
        .waddr (bus.w_adr_i),
        .wdata (bus.w_dat_i),
        .re    (mem_re),
        .raddr (bus.r_adr_i),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_wb_xfer_buffer.sv
// Testbench for wb_xfer_buffer. The reference model is a word array holding
// what the buffer should contain, a count of accepted fill writes and a
// sticky error flag, all updated from the buffer's stated rules.
module tb_wb_xfer_buffer;
    import wb_xfer_buffer_pkg::*;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned SBITS  = 10;
    localparam int unsigned COUNT  = 575;
    localparam int unsigned WORDS  = COUNT + 1;
    localparam logic [WIDTH-1:0] PAT = 32'hA5A5A5A5;
    localparam int BUDGET = 5000;

    logic clk_i = 1'b0;
    logic rst_i, enable_i;
    logic fetch_o, valid_o, error_o;

    int checks   = 0;
    int failures = 0;
    bit err_model = 1'b0;
    logic [WIDTH-1:0] ref_mem [WORDS];

    wb_xfer_buffer_if #(.WIDTH(WIDTH), .SBITS(SBITS)) bus ();

    wb_xfer_buffer #(
        .WIDTH (WIDTH),
        .SBITS (SBITS),
        .COUNT (COUNT),
        .DELAY (3)
    ) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .enable_i (enable_i),
        .fetch_o  (fetch_o),
        .valid_o  (valid_o),
        .error_o  (error_o),
        .bus      (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_write();
        bus.w_cyc_i = 1'b0; bus.w_stb_i = 1'b0; bus.w_we_i = 1'b0; bus.w_bst_i = 1'b0;
        bus.w_adr_i = '0;   bus.w_dat_i = '0;
    endtask

    task automatic idle_read();
        bus.r_cyc_i = 1'b0; bus.r_stb_i = 1'b0; bus.r_we_i = 1'b0; bus.r_adr_i = '0;
    endtask

    task automatic drive_write(input logic [SBITS-1:0] adr, input logic [WIDTH-1:0] dat);
        bus.w_cyc_i = 1'b1; bus.w_stb_i = 1'b1; bus.w_we_i = 1'b1;
        bus.w_adr_i = adr;  bus.w_dat_i = dat;
    endtask

    task automatic drive_read(input logic [SBITS-1:0] adr, input logic we);
        bus.r_cyc_i = 1'b1; bus.r_stb_i = 1'b1; bus.r_we_i = we; bus.r_adr_i = adr;
    endtask

    // Fill until WORDS in-range writes were accepted. Sequential mode writes
    // addr^PAT in address order and forces one write to address 600; random
    // mode uses random addresses/data. enable_i is randomised throughout since
    // it must not affect an ongoing fill.
    task automatic run_fill(input bit sequential, input bit hold_read);
        int accepted = 0;
        int cycles   = 0;
        bit wrote;
        bit bad;
        bit bad_done = 1'b0;
        logic [SBITS-1:0] adr;
        logic [WIDTH-1:0] dat;
        if (hold_read) drive_read(SBITS'(3), 1'b0);
        while (accepted < int'(WORDS) && cycles < BUDGET) begin
            cycles++;
            wrote = 1'b0;
            enable_i = 1'($urandom_range(1));
            bad = ($urandom_range(19) == 0) || (sequential && accepted == 300 && !bad_done);
            if (bad) begin
                adr = (sequential && !bad_done) ? SBITS'(600) : SBITS'($urandom_range(1023, WORDS));
                drive_write(adr, WIDTH'($urandom));
                err_model = 1'b1;
                bad_done  = 1'b1;
                wrote     = 1'b1;
            end else if ($urandom_range(3) == 0) begin
                idle_write();
            end else begin
                adr = sequential ? SBITS'(accepted) : SBITS'($urandom_range(COUNT));
                dat = sequential ? (WIDTH'(accepted) ^ PAT) : WIDTH'($urandom);
                drive_write(adr, dat);
                ref_mem[adr] = dat;
                accepted++;
                wrote = 1'b1;
            end
            #1;
            if (hold_read) begin
                checks++; if (bus.r_wat_o !== 1'b1) begin failures++; $display("FAIL fill_r_wat: got %b expected 1 at accepted=%0d", bus.r_wat_o, accepted); end
            end
            checks++; if (bus.w_wat_o !== 1'b0) begin failures++; $display("FAIL fill_w_wat: got %b expected 0", bus.w_wat_o); end
            tick();
            checks++; if (bus.w_ack_o !== wrote) begin failures++; $display("FAIL fill_w_ack: got %b expected %b", bus.w_ack_o, wrote); end
            checks++; if (valid_o !== (accepted == int'(WORDS))) begin failures++; $display("FAIL fill_valid: got %b expected %b at accepted=%0d", valid_o, accepted == int'(WORDS), accepted); end
            checks++; if (error_o !== err_model) begin failures++; $display("FAIL fill_error: got %b expected %b", error_o, err_model); end
            checks++; if (fetch_o !== 1'b0) begin failures++; $display("FAIL fill_fetch: got %b expected 0", fetch_o); end
            checks++; if (bus.r_ack_o !== 1'b0) begin failures++; $display("FAIL fill_r_ack: got %b expected 0", bus.r_ack_o); end
        end
        idle_write();
        if (accepted < int'(WORDS)) begin
            checks++; failures++;
            $display("FAIL fill_timeout: accepted %0d expected %0d", accepted, WORDS);
        end
    endtask

    task automatic test_reset();
        idle_write();
        drive_read(SBITS'(1), 1'b0);
        enable_i = 1'b0;
        rst_i    = 1'b1;
        repeat (3) tick();
        checks++; if ({fetch_o, valid_o, error_o, bus.w_ack_o, bus.w_wat_o, bus.r_ack_o, bus.r_wat_o} !== 7'b0) begin
            failures++; $display("FAIL reset_outputs: got %b expected 0000000",
                {fetch_o, valid_o, error_o, bus.w_ack_o, bus.w_wat_o, bus.r_ack_o, bus.r_wat_o}); end
        checks++; if (bus.r_dat_o !== '0) begin failures++; $display("FAIL reset_r_dat: got %h expected 0", bus.r_dat_o); end
        idle_read();
        err_model = 1'b0;
    endtask

    task automatic test_fetch();
        rst_i    = 1'b0;
        enable_i = 1'b1;
        tick();
        checks++; if (fetch_o !== 1'b1) begin failures++; $display("FAIL fetch_pulse: got %b expected 1", fetch_o); end
        repeat (3) begin
            tick();
            checks++; if (fetch_o !== 1'b0) begin failures++; $display("FAIL fetch_single: got %b expected 0", fetch_o); end
            checks++; if (valid_o !== 1'b0 || bus.w_wat_o !== 1'b0) begin failures++; $display("FAIL fetch_fill_state: valid=%b w_wat=%b expected 0 0", valid_o, bus.w_wat_o); end
        end
    endtask

    task automatic test_partial_reset();
        for (int i = 0; i < 100; i++) begin
            drive_write(SBITS'(i), WIDTH'($urandom));
            tick();
            checks++; if (bus.w_ack_o !== 1'b1 || valid_o !== 1'b0) begin failures++; $display("FAIL partial_write: ack=%b valid=%b expected 1 0", bus.w_ack_o, valid_o); end
        end
        idle_write();
        #2;
        rst_i = 1'b1;
        #1;
        checks++; if ({fetch_o, valid_o, error_o, bus.w_ack_o, bus.w_wat_o, bus.r_ack_o, bus.r_wat_o} !== 7'b0) begin
            failures++; $display("FAIL async_reset_outputs: got %b expected 0000000",
                {fetch_o, valid_o, error_o, bus.w_ack_o, bus.w_wat_o, bus.r_ack_o, bus.r_wat_o}); end
        err_model = 1'b0;
        repeat (3) begin
            tick();
            checks++; if (fetch_o !== 1'b0) begin failures++; $display("FAIL fetch_in_reset: got %b expected 0", fetch_o); end
        end
        rst_i = 1'b0;
        tick();
        checks++; if (fetch_o !== 1'b1) begin failures++; $display("FAIL refetch_after_reset: got %b expected 1", fetch_o); end
    endtask

    task automatic test_fill();
        run_fill(1'b1, 1'b1);
        enable_i = 1'b1;
        #1;
        checks++; if (bus.r_wat_o !== 1'b0) begin failures++; $display("FAIL stalled_r_wat_release: got %b expected 0", bus.r_wat_o); end
        tick();
        checks++; if (bus.r_ack_o !== 1'b1) begin failures++; $display("FAIL stalled_r_ack: got %b expected 1", bus.r_ack_o); end
        checks++; if (bus.r_dat_o !== ref_mem[3]) begin failures++; $display("FAIL stalled_r_dat: got %h expected %h", bus.r_dat_o, ref_mem[3]); end
        idle_read();
        tick();
        checks++; if (bus.r_ack_o !== 1'b0) begin failures++; $display("FAIL stalled_single_ack: got %b expected 0", bus.r_ack_o); end
    endtask

    task automatic test_read_stream();
        drive_write(SBITS'(10), ~ref_mem[10]);
        #1;
        checks++; if (bus.w_wat_o !== 1'b1) begin failures++; $display("FAIL ready_w_wat: got %b expected 1", bus.w_wat_o); end
        tick();
        err_model = 1'b1;
        checks++; if (bus.w_ack_o !== 1'b1 || error_o !== 1'b1) begin failures++; $display("FAIL ready_write_discard: ack=%b error=%b expected 1 1", bus.w_ack_o, error_o); end
        idle_write();
        drive_read(SBITS'(COUNT), 1'b1);
        #1;
        checks++; if (bus.r_wat_o !== 1'b0) begin failures++; $display("FAIL ctrl_strobe_wat: got %b expected 0", bus.r_wat_o); end
        tick();
        checks++; if (bus.r_ack_o !== 1'b1 || valid_o !== 1'b1) begin failures++; $display("FAIL ctrl_strobe: ack=%b valid=%b expected 1 1", bus.r_ack_o, valid_o); end
        for (int a = 0; a < int'(WORDS); a++) begin
            drive_read(SBITS'(a), 1'b0);
            tick();
            checks++; if (bus.r_ack_o !== 1'b1 || bus.r_dat_o !== ref_mem[a]) begin
                failures++; $display("FAIL stream_read: addr %0d ack=%b data=%h expected 1 %h", a, bus.r_ack_o, bus.r_dat_o, ref_mem[a]); end
            checks++; if (valid_o !== (a != int'(COUNT))) begin failures++; $display("FAIL stream_valid: addr %0d got %b", a, valid_o); end
        end
        idle_read();
        tick();
        checks++; if (fetch_o !== 1'b1 || bus.r_ack_o !== 1'b0) begin failures++; $display("FAIL drain_refetch: fetch=%b ack=%b expected 1 0", fetch_o, bus.r_ack_o); end
        checks++; if (error_o !== err_model) begin failures++; $display("FAIL error_sticky: got %b expected %b", error_o, err_model); end
    endtask

    task automatic test_random_round();
        int kind;
        logic [SBITS-1:0] adr;
        run_fill(1'b0, 1'b0);
        enable_i = 1'b0;
        for (int i = 0; i < 300; i++) begin
            kind = int'($urandom_range(7));
            adr  = SBITS'($urandom_range(COUNT - 1));
            if (kind == 0) idle_read();
            else drive_read(adr, kind == 1);
            tick();
            checks++; if (bus.r_ack_o !== (kind != 0)) begin failures++; $display("FAIL rand_read_ack: got %b expected %b", bus.r_ack_o, kind != 0); end
            if (kind >= 2) begin
                checks++; if (bus.r_dat_o !== ref_mem[adr]) begin failures++; $display("FAIL rand_read_data: addr %0d got %h expected %h", adr, bus.r_dat_o, ref_mem[adr]); end
            end
            checks++; if (valid_o !== 1'b1) begin failures++; $display("FAIL rand_read_valid: got %b expected 1", valid_o); end
        end
        drive_read(SBITS'(COUNT), 1'b0);
        tick();
        checks++; if (bus.r_ack_o !== 1'b1 || bus.r_dat_o !== ref_mem[COUNT] || valid_o !== 1'b0) begin
            failures++; $display("FAIL last_read: ack=%b data=%h valid=%b expected 1 %h 0", bus.r_ack_o, bus.r_dat_o, valid_o, ref_mem[COUNT]); end
        idle_read();
        repeat (4) begin
            tick();
            checks++; if (fetch_o !== 1'b0 || valid_o !== 1'b0) begin failures++; $display("FAIL hold_empty: fetch=%b valid=%b expected 0 0", fetch_o, valid_o); end
        end
        drive_read(SBITS'(2), 1'b0);
        #1;
        checks++; if (bus.r_wat_o !== 1'b1) begin failures++; $display("FAIL empty_r_wat: got %b expected 1", bus.r_wat_o); end
        tick();
        checks++; if (bus.r_ack_o !== 1'b0) begin failures++; $display("FAIL empty_no_ack: got %b expected 0", bus.r_ack_o); end
        idle_read();
        enable_i = 1'b1;
        tick();
        checks++; if (fetch_o !== 1'b1) begin failures++; $display("FAIL enable_fetch: got %b expected 1", fetch_o); end
    endtask

    task automatic test_empty_write();
        rst_i = 1'b1;
        err_model = 1'b0;
        #1;
        checks++; if (error_o !== err_model) begin failures++; $display("FAIL reset_clears_error: got %b expected 0", error_o); end
        tick();
        enable_i = 1'b0;
        rst_i    = 1'b0;
        tick();
        drive_write(SBITS'(5), WIDTH'($urandom));
        #1;
        checks++; if (bus.w_wat_o !== 1'b0) begin failures++; $display("FAIL empty_w_wat: got %b expected 0", bus.w_wat_o); end
        tick();
        err_model = 1'b1;
        checks++; if (bus.w_ack_o !== 1'b1 || error_o !== err_model || fetch_o !== 1'b0) begin
            failures++; $display("FAIL empty_write: ack=%b error=%b fetch=%b expected 1 1 0", bus.w_ack_o, error_o, fetch_o); end
        idle_write();
        tick();
        checks++; if (bus.w_ack_o !== 1'b0 || error_o !== err_model) begin failures++; $display("FAIL empty_error_sticky: ack=%b error=%b expected 0 1", bus.w_ack_o, error_o); end
    endtask

    initial begin
        idle_write();
        idle_read();
        test_reset();
        test_fetch();
        test_partial_reset();
        test_fill();
        test_read_stream();
        test_random_round();
        test_empty_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
